// File: rtl/rca_dispatch_scheduler.sv
// RCA dispatch scheduler: launches issued instructions on accelerator
// slots, captures results and round-robins them onto writeback.
module rca_dispatch_scheduler #(
  parameter int NUM_RCAS = 3,
  parameter int SEL_W    = 2,
  parameter int XLEN     = 32,
  parameter int ID_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_new,
  output logic                     issue_ready,
  input  logic [ID_W-1:0]          issue_id,
  input  logic [SEL_W-1:0]         issue_rca_sel,
  input  logic [XLEN-1:0]          issue_rs1,
  input  logic [XLEN-1:0]          issue_rs2,
  output logic [NUM_RCAS-1:0]      rca_start,
  output logic [XLEN-1:0]          rca_rs1,
  output logic [XLEN-1:0]          rca_rs2,
  input  logic [NUM_RCAS-1:0]      rca_done,
  input  logic [NUM_RCAS*XLEN-1:0] rca_result,
  output logic                     wb_done,
  output logic [ID_W-1:0]          wb_id,
  output logic [XLEN-1:0]          wb_rd,
  input  logic                     wb_ack,
  output logic                     err_spurious
);

  localparam int NSEL = 2**SEL_W;
  localparam logic [31:0] NUM_U = NUM_RCAS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           st       [NUM_RCAS];
  logic [ID_W-1:0]  slot_id  [NUM_RCAS];
  logic [XLEN-1:0]  slot_res [NUM_RCAS];

  logic [NUM_RCAS-1:0] idle;
  logic [NUM_RCAS-1:0] hold;
  logic [NSEL-1:0]     idle_ext;
  logic [NSEL-1:0]     hold_ext;
  logic [NSEL-1:0]     sel_oh;
  logic                sel_ok;
  logic                accept;
  logic                wb_free;
  logic                gnt_found;
  logic                grant;
  logic [SEL_W-1:0]    gnt_idx;
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    ptr_nxt;
  logic [SEL_W:0]      scan;

  // Decode per-slot state into IDLE / HOLD vectors
  always_comb begin
    idle = '0;
    hold = '0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      idle[i] = (st[i] == IDLE);
      hold[i] = (st[i] == HOLD);
    end
  end

  assign idle_ext    = NSEL'(idle);
  assign hold_ext    = NSEL'(hold);
  assign sel_ok      = 32'(issue_rca_sel) < NUM_U;
  assign issue_ready = sel_ok & idle_ext[issue_rca_sel];
  assign accept      = issue_new & issue_ready;
  assign sel_oh      = NSEL'(1) << issue_rca_sel;
  assign wb_free     = ~wb_done | wb_ack;
  assign grant       = wb_free & gnt_found;

  // Round-robin scan for the first HOLD slot starting at the pointer
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_RCAS; k++) begin
      scan = {1'b0, ptr} + (SEL_W+1)'(k);
      if (scan >= (SEL_W+1)'(NUM_RCAS))
        scan = scan - (SEL_W+1)'(NUM_RCAS);
      if (!gnt_found && hold_ext[scan[SEL_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[SEL_W-1:0];
      end
    end
  end

  // Pointer advances past the granted slot, wrapping at NUM_RCAS
  always_comb begin
    ptr_nxt = gnt_idx + SEL_W'(1);
    if (gnt_idx == SEL_W'(NUM_RCAS - 1))
      ptr_nxt = '0;
  end

  // Per-slot FSM: launch, capture result, release on writeback grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_spurious <= 1'b0;
      for (int i = 0; i < NUM_RCAS; i++) begin
        st[i]       <= IDLE;
        slot_id[i]  <= '0;
        slot_res[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        unique case (st[i])
          IDLE: begin
            if (accept && issue_rca_sel == SEL_W'(i)) begin
              st[i]      <= BUSY;
              slot_id[i] <= issue_id;
            end
            if (rca_done[i])
              err_spurious <= 1'b1;
          end
          BUSY: begin
            if (rca_done[i]) begin
              st[i]       <= HOLD;
              slot_res[i] <= rca_result[i*XLEN +: XLEN];
            end
          end
          HOLD: begin
            if (grant && gnt_idx == SEL_W'(i))
              st[i] <= IDLE;
            if (rca_done[i])
              err_spurious <= 1'b1;
          end
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

  // Start pulse and shared operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rca_start <= '0;
      rca_rs1   <= '0;
      rca_rs2   <= '0;
    end else begin
      rca_start <= accept ? sel_oh[NUM_RCAS-1:0] : '0;
      if (accept) begin
        rca_rs1 <= issue_rs1;
        rca_rs2 <= issue_rs2;
      end
    end
  end

  // One-entry writeback buffer with round-robin refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_done <= 1'b0;
      wb_id   <= '0;
      wb_rd   <= '0;
      ptr     <= '0;
    end else if (wb_free) begin
      if (gnt_found) begin
        wb_done <= 1'b1;
        wb_id   <= slot_id[gnt_idx];
        wb_rd   <= slot_res[gnt_idx];
        ptr     <= ptr_nxt;
      end else begin
        wb_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rca_dispatch_scheduler.sv
// Bench for rca_dispatch_scheduler: directed vectors, writeback
// results checked against a queue of expected {id, result}.
module tb_rca_dispatch_scheduler;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int XL = 32;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_new;
  logic            issue_ready;
  logic [IW-1:0]   issue_id;
  logic [SW-1:0]   issue_rca_sel;
  logic [XL-1:0]   issue_rs1;
  logic [XL-1:0]   issue_rs2;
  logic [N-1:0]    rca_start;
  logic [XL-1:0]   rca_rs1;
  logic [XL-1:0]   rca_rs2;
  logic [N-1:0]    rca_done;
  logic [N*XL-1:0] rca_result;
  logic            wb_done;
  logic [IW-1:0]   wb_id;
  logic [XL-1:0]   wb_rd;
  logic            wb_ack;
  logic            err_spurious;

  int checks = 0;
  int errors = 0;
  logic [IW+XL-1:0] sb [$];

  rca_dispatch_scheduler #(
    .NUM_RCAS(N), .SEL_W(SW), .XLEN(XL), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_new(issue_new), .issue_ready(issue_ready),
    .issue_id(issue_id), .issue_rca_sel(issue_rca_sel),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .rca_start(rca_start), .rca_rs1(rca_rs1), .rca_rs2(rca_rs2),
    .rca_done(rca_done), .rca_result(rca_result),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_ack(wb_ack), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted writeback must match the next queued entry
  always @(negedge clk) begin
    if (!rst && wb_done && wb_ack) begin
      logic [IW+XL-1:0] e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual id=%0h rd=%0h required none",
                 wb_id, wb_rd);
      end else begin
        e = sb.pop_front();
        chk("wb_id", 64'(wb_id), 64'(e[XL +: IW]));
        chk("wb_rd", 64'(wb_rd), 64'(e[XL-1:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [IW-1:0] id, input logic [XL-1:0] rd);
    sb.push_back({id, rd});
  endtask

  task automatic do_issue(input logic [IW-1:0] id, input logic [SW-1:0] sel,
                          input logic [XL-1:0] a, input logic [XL-1:0] b);
    logic [N-1:0] e;
    e = N'(1) << sel;
    issue_new = 1'b1;
    issue_id = id;
    issue_rca_sel = sel;
    issue_rs1 = a;
    issue_rs2 = b;
    @(negedge clk);
    chk("issue_ready", 64'(issue_ready), 64'd1);
    step();
    issue_new = 1'b0;
    @(negedge clk);
    chk("rca_start", 64'(rca_start), 64'(e));
    chk("rca_rs1", 64'(rca_rs1), 64'(a));
    chk("rca_rs2", 64'(rca_rs2), 64'(b));
    step();
  endtask

  task automatic do_done(input logic [N-1:0] m, input logic [XL-1:0] r0,
                         input logic [XL-1:0] r1, input logic [XL-1:0] r2);
    rca_result = {r2, r1, r0};
    rca_done = m;
    step();
    rca_done = '0;
  endtask

  initial begin
    rst = 1'b1;
    issue_new = 1'b0;
    issue_id = '0;
    issue_rca_sel = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    rca_done = '0;
    rca_result = '0;
    wb_ack = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_start", 64'(rca_start), 64'd0);
    chk("rst_wb_done", 64'(wb_done), 64'd0);
    chk("rst_wb_id", 64'(wb_id), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_rs1", 64'(rca_rs1), 64'd0);
    chk("rst_err", 64'(err_spurious), 64'd0);
    step();
    rst = 1'b0;
    step();

    // zero-latency done, writeback held until ack
    issue_new = 1'b1;
    issue_id = 3'd2;
    issue_rca_sel = 2'd0;
    issue_rs1 = 32'd5;
    issue_rs2 = 32'd7;
    @(negedge clk);
    chk("t1_ready", 64'(issue_ready), 64'd1);
    push(3'd2, 32'd12);
    step();
    issue_new = 1'b0;
    rca_done = 3'b001;
    rca_result = {32'd0, 32'd0, 32'd12};
    @(negedge clk);
    chk("t1_start", 64'(rca_start), 64'b001);
    chk("t1_rs1", 64'(rca_rs1), 64'd5);
    chk("t1_rs2", 64'(rca_rs2), 64'd7);
    step();
    rca_done = '0;
    @(negedge clk);
    chk("t1_start_off", 64'(rca_start), 64'd0);
    chk("t1_wb_early", 64'(wb_done), 64'd0);
    step();
    @(negedge clk);
    chk("t1_wb_done", 64'(wb_done), 64'd1);
    chk("t1_wb_id", 64'(wb_id), 64'd2);
    chk("t1_wb_rd", 64'(wb_rd), 64'd12);
    step();
    @(negedge clk);
    chk("t1_hold_done", 64'(wb_done), 64'd1);
    chk("t1_hold_rd", 64'(wb_rd), 64'd12);
    step();
    wb_ack = 1'b1;
    step();
    @(negedge clk);
    chk("t1_wb_fall", 64'(wb_done), 64'd0);
    step();

    // busy slot blocks issue until it is written back
    do_issue(3'd3, 2'd1, 32'd1, 32'd2);
    issue_new = 1'b1;
    issue_id = 3'd4;
    issue_rca_sel = 2'd1;
    issue_rs1 = 32'd9;
    issue_rs2 = 32'd8;
    @(negedge clk);
    chk("t2_busy_ready", 64'(issue_ready), 64'd0);
    step();
    rca_done = 3'b010;
    rca_result = {32'd0, 32'd100, 32'd0};
    push(3'd3, 32'd100);
    @(negedge clk);
    chk("t2_no_start", 64'(rca_start), 64'd0);
    chk("t2_ready_done", 64'(issue_ready), 64'd0);
    step();
    rca_done = '0;
    @(negedge clk);
    chk("t2_hold_ready", 64'(issue_ready), 64'd0);
    step();
    @(negedge clk);
    chk("t2_ready_again", 64'(issue_ready), 64'd1);
    chk("t2_wb", 64'(wb_done), 64'd1);
    step();
    issue_new = 1'b0;
    @(negedge clk);
    chk("t2_start", 64'(rca_start), 64'b010);
    chk("t2_rs1", 64'(rca_rs1), 64'd9);
    step();
    push(3'd4, 32'd44);
    do_done(3'b010, 32'd0, 32'd44, 32'd0);
    idle(4);

    // pointer at 2: slot 2 written back before slot 1
    do_issue(3'd5, 2'd1, 32'd10, 32'd11);
    do_issue(3'd6, 2'd2, 32'd12, 32'd13);
    push(3'd6, 32'h22);
    push(3'd5, 32'h11);
    do_done(3'b110, 32'd0, 32'h11, 32'h22);
    idle(4);
    do_issue(3'd7, 2'd2, 32'd1, 32'd1);
    push(3'd7, 32'h77);
    do_done(3'b100, 32'd0, 32'd0, 32'h77);
    idle(4);

    // three simultaneous holds, ack held high: back-to-back in slot order
    do_issue(3'd1, 2'd0, 32'd1, 32'd1);
    do_issue(3'd2, 2'd1, 32'd2, 32'd2);
    do_issue(3'd3, 2'd2, 32'd3, 32'd3);
    push(3'd1, 32'hA0);
    push(3'd2, 32'hA1);
    push(3'd3, 32'hA2);
    do_done(3'b111, 32'hA0, 32'hA1, 32'hA2);
    @(negedge clk);
    chk("t3_pre", 64'(wb_done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t3_b2b", 64'(wb_done), 64'd1);
    end
    step();
    @(negedge clk);
    chk("t3_post", 64'(wb_done), 64'd0);
    step();
    do_issue(3'd4, 2'd1, 32'd4, 32'd4);
    do_issue(3'd5, 2'd2, 32'd5, 32'd5);
    push(3'd4, 32'hB1);
    push(3'd5, 32'hB2);
    do_done(3'b110, 32'd0, 32'hB1, 32'hB2);
    idle(4);

    // spurious done on idle slot 2
    @(negedge clk);
    chk("t5_err_clear", 64'(err_spurious), 64'd0);
    step();
    do_done(3'b100, 32'd0, 32'd0, 32'hDEAD);
    @(negedge clk);
    chk("t5_err_set", 64'(err_spurious), 64'd1);
    chk("t5_no_wb", 64'(wb_done), 64'd0);
    idle(3);
    @(negedge clk);
    chk("t5_err_sticky", 64'(err_spurious), 64'd1);
    chk("t5_no_wb2", 64'(wb_done), 64'd0);
    step();

    // reset while slot 0 busy and writeback pending
    wb_ack = 1'b0;
    do_issue(3'd6, 2'd1, 32'h61, 32'h62);
    do_done(3'b010, 32'd0, 32'h66, 32'd0);
    do_issue(3'd7, 2'd0, 32'h71, 32'h72);
    @(negedge clk);
    chk("t6_wb_pending", 64'(wb_done), 64'd1);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_wb_done", 64'(wb_done), 64'd0);
    chk("t6_rst_wb_id", 64'(wb_id), 64'd0);
    chk("t6_rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("t6_rst_rs1", 64'(rca_rs1), 64'd0);
    chk("t6_rst_rs2", 64'(rca_rs2), 64'd0);
    chk("t6_rst_err", 64'(err_spurious), 64'd0);
    chk("t6_rst_start", 64'(rca_start), 64'd0);
    step();
    rst = 1'b0;
    wb_ack = 1'b1;
    issue_rca_sel = 2'd0;
    @(negedge clk);
    chk("t6_ready0", 64'(issue_ready), 64'd1);
    issue_rca_sel = 2'd3;
    #1;
    chk("t6_ready_bad_sel", 64'(issue_ready), 64'd0);
    step();
    do_done(3'b001, 32'h55, 32'd0, 32'd0);
    @(negedge clk);
    chk("t6_err_after", 64'(err_spurious), 64'd1);
    chk("t6_no_wb", 64'(wb_done), 64'd0);
    idle(3);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_dispatch_scheduler.md
Name: rca_dispatch_scheduler

Overview:
Sequences the reconfigurable custom accelerators (RCAs) behind the Taiga unit issue/writeback interfaces.
- Accepts an issued RCA instruction and launches it on the selected accelerator slot with registered operands.
- Captures each slot's result when the slot signals done.
- Round-robin arbitrates completed slots onto the single writeback port.
- Sits between Taiga issue/writeback and the NUM_RCAS accelerator instances.

Parameters:
NUM_RCAS, 3, number of accelerator slots (1..4)
SEL_W, 2, width of slot select; 2**SEL_W >= NUM_RCAS
XLEN, 32, operand/result width
ID_W, 3, Taiga instruction id width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
issue_new  input  1  Taiga issues an instruction to this unit this cycle
issue_ready  output  1  unit can accept the instruction presented
issue_id  input  ID_W  instruction id
issue_rca_sel  input  SEL_W  target slot
issue_rs1  input  XLEN  operand 1
issue_rs2  input  XLEN  operand 2
rca_start  output  NUM_RCAS  one-cycle start pulse per slot
rca_rs1  output  XLEN  registered operand 1 (shared by all slots)
rca_rs2  output  XLEN  registered operand 2 (shared by all slots)
rca_done  input  NUM_RCAS  per-slot completion pulse
rca_result  input  NUM_RCAS*XLEN  per-slot result, slot i at bits [i*XLEN +: XLEN]
wb_done  output  1  writeback valid
wb_id  output  ID_W  id of the result being written back
wb_rd  output  XLEN  result data
wb_ack  input  1  Taiga accepts the writeback this cycle
err_spurious  output  1  sticky: rca_done seen on a slot that was not BUSY

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - Every slot returns to IDLE; all in-flight work is dropped.
  - rca_start, wb_done and err_spurious are 0.
  - wb_id, wb_rd, rca_rs1 and rca_rs2 are 0.
  - Round-robin pointer is 0.
- Per-slot state machine:
  - IDLE -> BUSY on accept.
  - BUSY -> HOLD on rca_done[i]; rca_result slice and id are captured.
  - HOLD -> IDLE when granted to writeback.
- issue_ready (combinational) = issue_rca_sel < NUM_RCAS AND slot[issue_rca_sel] is IDLE. It depends on current state only; a slot granted this cycle is not ready until the next cycle.
- Accept = issue_new & issue_ready at cycle T:
  - At T+1: rca_start[sel] = 1 for exactly one cycle; rca_rs1/rca_rs2 hold the accepted operands until the next accept; the slot's id is latched.
  - issue_new while not ready is ignored; no state change.
- rca_done[i] counts in any BUSY cycle, including the rca_start cycle (zero-latency accelerators).
- rca_done[i] on an IDLE or HOLD slot is ignored and sets err_spurious, which is cleared only by rst.
- Writeback buffer (one entry):
  - Free when wb_done = 0, or when wb_done & wb_ack this cycle.
  - When free and any slot is in HOLD: grant the first HOLD slot found scanning from the pointer upward with wrap; load wb_id/wb_rd; wb_done = 1 next cycle; pointer = (granted + 1) mod NUM_RCAS.
  - An ack and a new grant in the same cycle give back-to-back wb_done with no bubble.
  - With no grant, wb_done falls after the ack.
- wb_done/wb_id/wb_rd are stable while wb_done = 1 and wb_ack = 0.
- Minimum latency: accept at T, start at T+1, HOLD at T+2, wb_done at T+3.
- Simultaneous events:
  - Accept and done on different slots in the same cycle: both take effect.
  - Each slot holds at most one instruction; slots complete out of order; wb_id identifies the instruction.

Test Plan:
- Reset, then issue id=2 sel=0 rs1=5 rs2=7; slot 0 returns done with result 12 in the start cycle -> rca_start=001 at T+1, wb_done=1 with wb_id=2 and wb_rd=12 at T+3, held until wb_ack.
- Slot 1 is BUSY; issue_new with sel=1 -> issue_ready=0, no rca_start; after its done and grant, the same issue is accepted the following cycle.
- Slots 0, 1 and 2 enter HOLD in the same cycle with wb_ack held at 1 -> wb_done stays high 3 consecutive cycles, ids in slot order 0,1,2; then the pointer is 0 again.
- Slots 1 and 2 enter HOLD with the pointer at 2 -> slot 2 is written back before slot 1.
- rca_done[2] pulses while slot 2 is IDLE -> err_spurious=1 and stays 1; no wb_done.
- rst asserted while slot 0 is BUSY and wb_done=1 -> all outputs 0 immediately; a later rca_done[0] sets err_spurious.
